// File: rtl/mac_accumulator.sv
// Sums K multiplier products per frame; frame sum registered 1 clock after the K-th product strobe.
// One-entry valid/ready output; accumulation never stalls, unaccepted sums are overwritten (overrun).
module mac_accumulator #(
  parameter  int unsigned N  = 16,
  parameter  int unsigned G  = 4,
  parameter  int unsigned K  = 8,
  localparam int unsigned AW = 2*N + G,
  localparam int unsigned CW = $clog2(K+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2*N-1:0] prod,
  input  logic          finished,
  input  logic          clr,
  output logic [AW-1:0] sum_out,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          overrun
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [CW-1:0] LAST = CW'(K-1);

  state_t        state_q, state_d;
  logic          fin_q;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] sum_q, sum_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          ovr_q, ovr_d;
  logic          pstb;
  logic          frame_done;
  logic [AW:0]   add;

  always_comb begin
    pstb       = finished & ~fin_q;
    add        = {1'b0, acc_q} + (AW+1)'(prod);
    acc_d      = acc_q;
    count_d    = count_q;
    sum_d      = sum_q;
    ovf_d      = ovf_q;
    ovr_d      = ovr_q;
    state_d    = state_q;
    frame_done = 1'b0;

    // clr wins over a coincident strobe: that product is dropped
    if (clr) begin
      acc_d   = '0;
      count_d = '0;
    end else if (pstb) begin
      ovf_d = ovf_q | add[AW];
      if (count_q == LAST) begin
        frame_done = 1'b1;
        sum_d      = add[AW-1:0];
        acc_d      = '0;
        count_d    = '0;
      end else begin
        acc_d   = add[AW-1:0];
        count_d = count_q + CW'(1);
      end
    end

    case (state_q)
      EMPTY: if (frame_done) state_d = FULL;
      FULL: begin
        // completing with ready is accept-plus-reload, not an overrun
        if (frame_done) begin
          if (!sum_ready) ovr_d = 1'b1;
        end else if (sum_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      fin_q   <= 1'b1;
      acc_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= finished;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = (state_q == FULL);
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: K=4 frame/backpressure/abort checks plus a K=17 build to reach carry-out.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] prod = '0;
  logic        finished = 1'b0;
  logic        clr = 1'b0;
  logic        sum_ready = 1'b1;
  logic [35:0] sum_out;
  logic        sum_valid;
  logic [2:0]  count;
  logic        ovf, overrun;

  logic [31:0] prod2 = '0;
  logic        finished2 = 1'b0;
  logic        clr2 = 1'b0;
  logic        sum_ready2 = 1'b1;
  logic [35:0] sum_out2;
  logic        sum_valid2;
  logic [4:0]  count2;
  logic        ovf2, overrun2;

  int n_vec = 0;
  int n_bad = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  mac_accumulator #(.N(16), .G(4), .K(4)) dut (
    .clk(clk), .rst(rst), .prod(prod), .finished(finished), .clr(clr),
    .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .count(count), .ovf(ovf), .overrun(overrun)
  );

  // Out-of-range K so a frame can actually carry out of the accumulator
  mac_accumulator #(.N(16), .G(4), .K(17)) dut_ovf (
    .clk(clk), .rst(rst), .prod(prod2), .finished(finished2), .clr(clr2),
    .sum_out(sum_out2), .sum_valid(sum_valid2), .sum_ready(sum_ready2),
    .count(count2), .ovf(ovf2), .overrun(overrun2)
  );

  typedef struct {
    logic [31:0] p;
    logic        c;
    logic        r;
    logic [2:0]  cnt;
    logic        chk;
    logic        vld;
    logic [35:0] sum;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] p, input logic c, input logic r,
                              input logic [2:0] cnt, input logic chk, input logic vld,
                              input logic [35:0] sum);
    vec_t v;
    v.p = p; v.c = c; v.r = r; v.cnt = cnt; v.chk = chk; v.vld = vld; v.sum = sum;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] p, input logic c, input logic r);
    prod = p; finished = 1'b1; clr = c; sum_ready = r;
    tick();
    clr = 1'b0;
  endtask

  task automatic tail();
    tick(); tick();
    finished = 1'b0;
    tick(); tick();
  endtask

  task automatic pulse2(input logic [31:0] p);
    prod2 = p; finished2 = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst && sum_valid === 1'b1 && sum_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL scoreboard: got unexpected sum 0x%0h, expected no output", sum_out);
      end else begin
        chk("scoreboard sum", 64'(sum_out), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, expected finish earlier");
    $fatal(1);
  end

  initial begin
    // basic frame
    tbl.push_back(mk(32'd3, 0, 1, 3'd1, 0, 0, 36'd0));
    tbl.push_back(mk(32'd5, 0, 1, 3'd2, 0, 0, 36'd0));
    tbl.push_back(mk(32'd7, 0, 1, 3'd3, 0, 0, 36'd0));
    tbl.push_back(mk(32'd9, 0, 1, 3'd0, 1, 1, 36'd24));
    // guard-bit frame
    tbl.push_back(mk(32'hFFFFFFFF, 0, 1, 3'd1, 0, 0, 36'd0));
    tbl.push_back(mk(32'hFFFFFFFF, 0, 1, 3'd2, 0, 0, 36'd0));
    tbl.push_back(mk(32'hFFFFFFFF, 0, 1, 3'd3, 0, 0, 36'd0));
    tbl.push_back(mk(32'hFFFFFFFF, 0, 1, 3'd0, 1, 1, 36'h3FFFFFFFC));
    // pending sum of 20, then abort mid-frame
    tbl.push_back(mk(32'd5, 0, 0, 3'd1, 0, 0, 36'd0));
    tbl.push_back(mk(32'd5, 0, 0, 3'd2, 0, 0, 36'd0));
    tbl.push_back(mk(32'd5, 0, 0, 3'd3, 0, 0, 36'd0));
    tbl.push_back(mk(32'd5, 0, 0, 3'd0, 1, 1, 36'd20));
    tbl.push_back(mk(32'd10, 0, 0, 3'd1, 1, 1, 36'd20));
    tbl.push_back(mk(32'd10, 0, 0, 3'd2, 1, 1, 36'd20));
    tbl.push_back(mk(32'd20, 1, 0, 3'd0, 1, 1, 36'd20));
    tbl.push_back(mk(32'd1, 0, 1, 3'd1, 0, 0, 36'd0));
    tbl.push_back(mk(32'd1, 0, 1, 3'd2, 0, 0, 36'd0));
    tbl.push_back(mk(32'd1, 0, 1, 3'd3, 0, 0, 36'd0));
    tbl.push_back(mk(32'd1, 0, 1, 3'd0, 1, 1, 36'd4));

    // reset with finished already high
    rst = 1'b1; finished = 1'b1;
    tick(); tick();
    chk("reset sum_out", 64'(sum_out), 64'd0);
    chk("reset sum_valid", 64'(sum_valid), 64'd0);
    chk("reset count", 64'(count), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);
    chk("reset overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("held-finished count c%0d", i), 64'(count), 64'd0);
      chk($sformatf("held-finished sum_valid c%0d", i), 64'(sum_valid), 64'd0);
    end
    finished = 1'b0;
    tick(); tick();

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      if (v.chk && v.vld && v.sum != sum_out) exp_q.push_back(v.sum);
      strobe(v.p, v.c, v.r);
      chk($sformatf("vec%0d count", i), 64'(count), 64'(v.cnt));
      if (v.chk) begin
        chk($sformatf("vec%0d sum_valid", i), 64'(sum_valid), 64'(v.vld));
        chk($sformatf("vec%0d sum_out", i), 64'(sum_out), 64'(v.sum));
      end
      tick();
      if (v.chk && v.vld && v.r)
        chk($sformatf("vec%0d sum_valid one cycle", i), 64'(sum_valid), 64'd0);
      tick();
      finished = 1'b0;
      tick(); tick();
    end
    chk("table ovf", 64'(ovf), 64'd0);
    chk("table overrun", 64'(overrun), 64'd0);

    // back-pressure: A overwritten by B
    for (int i = 0; i < 4; i++) begin strobe(32'd1, 0, 0); tail(); end
    chk("bp A sum_valid", 64'(sum_valid), 64'd1);
    chk("bp A sum_out", 64'(sum_out), 64'd4);
    for (int i = 0; i < 3; i++) begin
      strobe(32'd2, 0, 0); tail();
      chk($sformatf("bp A held p%0d", i), 64'(sum_out), 64'd4);
    end
    strobe(32'd2, 0, 0);
    chk("bp B sum_out", 64'(sum_out), 64'd8);
    chk("bp B sum_valid", 64'(sum_valid), 64'd1);
    chk("bp B overrun", 64'(overrun), 64'd1);
    tail();
    chk("bp overrun sticky", 64'(overrun), 64'd1);
    exp_q.push_back(36'd8);
    sum_ready = 1'b1;
    tick();
    chk("bp drained sum_valid", 64'(sum_valid), 64'd0);

    rst = 1'b1; finished = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post-reset overrun", 64'(overrun), 64'd0);

    // back-pressure: B completes together with ready
    exp_q.push_back(36'd4);
    for (int i = 0; i < 4; i++) begin strobe(32'd1, 0, 0); tail(); end
    for (int i = 0; i < 3; i++) begin strobe(32'd2, 0, 0); tail(); end
    exp_q.push_back(36'd8);
    strobe(32'd2, 0, 1);
    chk("reload sum_out", 64'(sum_out), 64'd8);
    chk("reload sum_valid", 64'(sum_valid), 64'd1);
    chk("reload overrun", 64'(overrun), 64'd0);
    tail();
    chk("reload drained sum_valid", 64'(sum_valid), 64'd0);
    chk("reload overrun after", 64'(overrun), 64'd0);

    // carry out of the accumulator on the 17th add
    for (int i = 1; i <= 18; i++) begin
      pulse2(32'hFFFFFFFF);
      if (i == 16) begin
        chk("wrap ovf before carry", 64'(ovf2), 64'd0);
        chk("wrap count 16", 64'(count2), 64'd16);
      end
      if (i == 17) begin
        chk("wrap ovf on carry", 64'(ovf2), 64'd1);
        chk("wrap sum_out", 64'(sum_out2), 64'h0FFFFFFEF);
        chk("wrap sum_valid", 64'(sum_valid2), 64'd1);
        chk("wrap count reset", 64'(count2), 64'd0);
      end
      tick(); tick();
      finished2 = 1'b0;
      tick(); tick();
    end
    chk("wrap ovf sticky", 64'(ovf2), 64'd1);

    tick(); tick();
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
